// File: rtl/scroll_scheduler.sv
// Frame-synchronous scroll controller: advances grass phase and cloud offset only at
// frame start, sequenced by game state (idle / running / dead) and a programmable speed.
module scroll_scheduler #(
    parameter int GRASS_PERIOD = 16,
    parameter int CLOUD_WIDTH  = 640,
    parameter int CLOUD_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       status_run,
    input  logic       status_dead,
    input  logic       restart,
    input  logic [3:0] speed,
    output logic [4:0] grass_pos,
    output logic [9:0] cloud_pos,
    output logic       step_strobe,
    output logic [1:0] scroll_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } state_t;

    localparam logic [4:0] GRASS_LAST = 5'(GRASS_PERIOD - 1);
    localparam logic [9:0] CLOUD_LAST = 10'(CLOUD_WIDTH - 1);
    localparam logic [7:0] DIV_LAST   = 8'(CLOUD_DIV - 1);

    state_t     state, state_nx;
    logic [3:0] frame_cnt, frame_cnt_nx;
    logic [7:0] div_cnt, div_nx;
    logic [4:0] grass_nx;
    logic [9:0] cloud_nx;
    logic       step;

    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        div_nx       = div_cnt;
        grass_nx     = grass_pos;
        cloud_nx     = cloud_pos;
        step         = 1'b0;

        if (restart) begin
            state_nx     = IDLE;
            frame_cnt_nx = 4'd0;
            div_nx       = 8'd0;
            grass_nx     = 5'd0;
            cloud_nx     = 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    frame_cnt_nx = 4'd0;
                    div_nx       = 8'd0;
                    grass_nx     = 5'd0;
                    cloud_nx     = 10'd0;
                    if (frame_start && status_run && !status_dead)
                        state_nx = RUN;
                end
                RUN: begin
                    // Death wins over a due step, even on a frame_start cycle.
                    if (status_dead) begin
                        state_nx = STOP;
                    end else if (!status_run) begin
                        state_nx     = IDLE;
                        frame_cnt_nx = 4'd0;
                        div_nx       = 8'd0;
                        grass_nx     = 5'd0;
                        cloud_nx     = 10'd0;
                    end else if (frame_start) begin
                        // speed is taken at frame_start, so a mid-frame change counts now.
                        if (frame_cnt >= speed) begin
                            step         = 1'b1;
                            frame_cnt_nx = 4'd0;
                        end else begin
                            frame_cnt_nx = frame_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                end
                default: state_nx = IDLE;
            endcase
        end

        if (step) begin
            grass_nx = (grass_pos == GRASS_LAST) ? 5'd0 : grass_pos + 5'd1;
            if (div_cnt == DIV_LAST) begin
                div_nx   = 8'd0;
                cloud_nx = (cloud_pos == CLOUD_LAST) ? 10'd0 : cloud_pos + 10'd1;
            end else begin
                div_nx = div_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_cnt   <= 4'd0;
            div_cnt     <= 8'd0;
            grass_pos   <= 5'd0;
            cloud_pos   <= 10'd0;
            step_strobe <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_cnt   <= frame_cnt_nx;
            div_cnt     <= div_nx;
            grass_pos   <= grass_nx;
            cloud_pos   <= cloud_nx;
            step_strobe <= step;
        end
    end

    assign scroll_state = state;

endmodule

// File: tb/tb_scroll_scheduler.sv
// Bench for scroll_scheduler: cycle scoreboard against a reference model, a vector table,
// and directed sequences for wrap, death, restart, speed change and reset.
module tb_scroll_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, frame_start, status_run, status_dead, restart;
    logic [3:0] speed;
    logic [4:0] a_grass, b_grass;
    logic [9:0] a_cloud, b_cloud;
    logic       a_stb, b_stb;
    logic [1:0] a_state, b_state;

    always #5 clk = ~clk;

    scroll_scheduler dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .status_run(status_run),
        .status_dead(status_dead), .restart(restart), .speed(speed),
        .grass_pos(a_grass), .cloud_pos(a_cloud), .step_strobe(a_stb), .scroll_state(a_state)
    );

    scroll_scheduler #(.CLOUD_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .status_run(status_run),
        .status_dead(status_dead), .restart(restart), .speed(speed),
        .grass_pos(b_grass), .cloud_pos(b_cloud), .step_strobe(b_stb), .scroll_state(b_state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [4:0] g;
        logic [9:0] c;
        logic       stb;
    } exp_t;

    typedef struct {
        logic       fs, run, dead, rs;
        logic [3:0] spd;
        logic [1:0] st;
        logic       stb;
        logic [4:0] g;
    } vec_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   a_cnt = 0, b_cnt = 0;
    logic cur_run = 1'b0, cur_dead = 1'b0;

    // Reference model state (CLOUD_DIV = 4 instance)
    logic [1:0] m_st;
    logic [4:0] m_g;
    logic [9:0] m_c;
    logic [3:0] m_fc;
    int         m_div;
    logic       m_stb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input logic rn, fs, run, dead, rs, input logic [3:0] spd);
        logic do_step;
        do_step = 1'b0;
        if (!rn || rs || m_st == 2'b00) begin
            if (!rn || rs) m_st = 2'b00;
            else if (fs && run && !dead) m_st = 2'b01;
            m_g = 0; m_c = 0; m_fc = 0; m_div = 0;
        end else if (m_st == 2'b01) begin
            if (dead) m_st = 2'b10;
            else if (!run) begin
                m_st = 2'b00; m_g = 0; m_c = 0; m_fc = 0; m_div = 0;
            end else if (fs) begin
                if (m_fc >= spd) begin do_step = 1'b1; m_fc = 0; end
                else m_fc = m_fc + 4'd1;
            end
        end
        if (do_step) begin
            m_g = (m_g == 5'd15) ? 5'd0 : m_g + 5'd1;
            if (m_div == 3) begin
                m_div = 0;
                m_c = (m_c == 10'd639) ? 10'd0 : m_c + 10'd1;
            end else m_div++;
        end
        m_stb = do_step;
    endtask

    task automatic cyc(input logic rn, fs, run, dead, rs, input logic [3:0] spd);
        exp_t e;
        rst_n = rn; frame_start = fs; status_run = run; status_dead = dead;
        restart = rs; speed = spd;
        model(rn, fs, run, dead, rs, spd);
        q.push_back('{st: m_st, g: m_g, c: m_c, stb: m_stb});
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("cycle_outputs", {14'd0, a_state, a_grass, a_cloud, a_stb}, {14'd0, e});
        a_cnt += int'(a_stb);
        b_cnt += int'(b_stb);
    endtask

    task automatic frames(input int n, input logic [3:0] spd);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, cur_run, cur_dead, 1'b0, spd);
            cyc(1'b1, 1'b0, cur_run, cur_dead, 1'b0, spd);
        end
    endtask

    vec_t tbl[8];

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; status_run = 1'b0;
        status_dead = 1'b0; restart = 1'b0; speed = 4'd0;
        m_st = 0; m_g = 0; m_c = 0; m_fc = 0; m_div = 0; m_stb = 0;

        tbl[0] = '{fs:1, run:1, dead:0, rs:1, spd:0, st:2'b00, stb:0, g:0};
        tbl[1] = '{fs:0, run:1, dead:0, rs:0, spd:0, st:2'b00, stb:0, g:0};
        tbl[2] = '{fs:1, run:1, dead:0, rs:0, spd:0, st:2'b01, stb:0, g:0};
        tbl[3] = '{fs:0, run:1, dead:0, rs:0, spd:0, st:2'b01, stb:0, g:0};
        tbl[4] = '{fs:1, run:1, dead:0, rs:0, spd:0, st:2'b01, stb:1, g:1};
        tbl[5] = '{fs:0, run:1, dead:0, rs:0, spd:0, st:2'b01, stb:0, g:1};
        tbl[6] = '{fs:0, run:0, dead:0, rs:0, spd:0, st:2'b00, stb:0, g:0};
        tbl[7] = '{fs:1, run:1, dead:0, rs:0, spd:0, st:2'b01, stb:0, g:0};

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check("reset_state", a_state, 2'b00);
        check("reset_grass", a_grass, 5'd0);
        check("reset_cloud", a_cloud, 10'd0);
        check("reset_strobe", a_stb, 1'b0);

        // 20 frames at speed 0: first frame only enters RUN
        cur_run = 1'b1; a_cnt = 0;
        frames(20, 4'd0);
        check("t1_state", a_state, 2'b01);
        check("t1_grass", a_grass, 5'd3);
        check("t1_cloud", a_cloud, 10'd4);
        check("t1_strobes", a_cnt, 19);

        // speed 3: one step every 4th frame
        a_cnt = 0;
        frames(12, 4'd3);
        check("t2_strobes", a_cnt, 3);
        check("t2_grass", a_grass, 5'd6);
        check("t2_cloud", a_cloud, 10'd5);

        // Death coinciding with a due step
        cur_dead = 1'b1; a_cnt = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check("t3_state", a_state, 2'b10);
        check("t3_nostep", a_stb, 1'b0);
        frames(5, 4'd0);
        check("t3_frozen_grass", a_grass, 5'd6);
        check("t3_frozen_cloud", a_cloud, 10'd5);
        check("t3_strobes", a_cnt, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        check("t3_restart_state", a_state, 2'b00);
        check("t3_restart_grass", a_grass, 5'd0);
        check("t3_restart_cloud", a_cloud, 10'd0);
        cur_dead = 1'b0;

        // Vector table: restart priority, RUN entry, first step, run drop
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, tbl[i].fs, tbl[i].run, tbl[i].dead, tbl[i].rs, tbl[i].spd);
            check($sformatf("tbl%0d_state", i), a_state, tbl[i].st);
            check($sformatf("tbl%0d_strobe", i), a_stb, tbl[i].stb);
            check($sformatf("tbl%0d_grass", i), a_grass, tbl[i].g);
        end

        // speed 15 -> 0 with frame_cnt at 5
        a_cnt = 0;
        frames(5, 4'd15);
        check("t5_nostep", a_cnt, 0);
        frames(1, 4'd0);
        check("t5_step", a_cnt, 1);
        check("t5_grass", a_grass, 5'd1);

        // Reset mid-run at grass 9
        frames(8, 4'd0);
        check("t6_pre_grass", a_grass, 5'd9);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("t6_state", a_state, 2'b00);
        check("t6_grass", a_grass, 5'd0);
        check("t6_cloud", a_cloud, 10'd0);
        check("t6_strobe", a_stb, 1'b0);

        // Joint wrap on the CLOUD_DIV=1 instance
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        frames(1, 4'd0);
        frames(639, 4'd0);
        check("t4_pre_grass", b_grass, 5'd15);
        check("t4_pre_cloud", b_cloud, 10'd639);
        b_cnt = 0;
        frames(1, 4'd0);
        check("t4_wrap_grass", b_grass, 5'd0);
        check("t4_wrap_cloud", b_cloud, 10'd0);
        check("t4_wrap_strobes", b_cnt, 1);
        check("t4_state", b_state, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
